// File: rtl/ifu_pc_ctrl.sv
// ifu_pc_ctrl: fetch-stage PC generator for the 5-stage MIPS pipeline.
// Takes the branch/jump result resolved in D, applies delayed-branch
// redirects (buffering one redirect when fetch cannot advance), and stops
// fetch permanently on a misaligned or out-of-range PC until reset.
module ifu_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    localparam int         AW       = $clog2(IM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          imem_ready,
    input  logic          br_req,
    input  logic [1:0]    br_type,
    input  logic          cmp_res,
    input  logic [31:0]   pc_d,
    input  logic [15:0]   imm16,
    input  logic [25:0]   instr_index,
    input  logic [31:0]   jr_addr,
    output logic [31:0]   pc_f,
    output logic [31:0]   pc_f_plus4,
    output logic [AW-1:0] imem_addr,
    output logic          fetch_valid,
    output logic          fault,
    output logic [31:0]   fault_pc,
    output logic [31:0]   fetch_cnt
);

    // One past the last legal byte address; 33 bits so the sum cannot wrap.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic [31:0] pendTarget_q, pendTarget_d;
    logic        fault_q, fault_d;
    logic [31:0] faultPc_q, faultPc_d;
    logic [31:0] fetchCnt_q, fetchCnt_d;

    logic        adv;
    logic        taken;
    logic [31:0] target;
    logic [31:0] nextPc;
    logic        commitReq;
    logic        nextLegal;
    logic [31:0] pcOffset;

    // Decode the resolved branch/jump into a taken flag and its target.
    // br_type 11 is handled exactly like a conditional branch.
    always_comb begin
        adv    = !stall && imem_ready && !fault_q;
        taken  = br_req && (((br_type == 2'b01) || (br_type == 2'b10)) ? 1'b1 : cmp_res);
        target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        case (br_type)
            2'b01:   target = {pc_d[31:28], instr_index, 2'b00};
            2'b10:   target = jr_addr;
            default: target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        endcase
    end

    // Next-state logic: choose the next fetch PC, buffer a redirect that
    // arrives while fetch is blocked, and turn an illegal commit into a
    // sticky fault instead of an update.
    always_comb begin
        state_d      = state_q;
        pcF_d        = pcF_q;
        pendTarget_d = pendTarget_q;
        fault_d      = fault_q;
        faultPc_d    = faultPc_q;
        fetchCnt_d   = fetchCnt_q;
        nextPc       = pcF_q + 32'd4;
        commitReq    = 1'b0;

        case (state_q)
            IDLE: begin
                if (adv) begin
                    commitReq = 1'b1;
                    nextPc    = taken ? target : (pcF_q + 32'd4);
                end else if (taken && !fault_q) begin
                    pendTarget_d = target;
                    state_d      = PENDING;
                end
            end
            PENDING: begin
                // A second redirect while one is buffered replaces it.
                if (taken && !fault_q) begin
                    pendTarget_d = target;
                end
                if (adv) begin
                    commitReq = 1'b1;
                    nextPc    = taken ? target : pendTarget_q;
                end
            end
            default: state_d = IDLE;
        endcase

        nextLegal = (nextPc[1:0] == 2'b00) &&
                    (nextPc >= RESET_PC) &&
                    ({1'b0, nextPc} < PC_LIMIT);

        if (commitReq) begin
            if (nextLegal) begin
                pcF_d      = nextPc;
                fetchCnt_d = fetchCnt_q + 32'd1;
                state_d    = IDLE;
            end else begin
                fault_d      = 1'b1;
                faultPc_d    = nextPc;
                state_d      = state_q;
                pendTarget_d = pendTarget_q;
            end
        end
    end

    // State registers; reset drops any buffered redirect and clears the fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pcF_q        <= RESET_PC;
            pendTarget_q <= 32'd0;
            fault_q      <= 1'b0;
            faultPc_q    <= 32'd0;
            fetchCnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcF_q        <= pcF_d;
            pendTarget_q <= pendTarget_d;
            fault_q      <= fault_d;
            faultPc_q    <= faultPc_d;
            fetchCnt_q   <= fetchCnt_d;
        end
    end

    // Outputs derived directly from the registered fetch PC.
    always_comb begin
        pcOffset    = pcF_q - RESET_PC;
        pc_f        = pcF_q;
        pc_f_plus4  = pcF_q + 32'd4;
        imem_addr   = pcOffset[AW+1:2];
        fetch_valid = !fault_q;
        fault       = fault_q;
        fault_pc    = faultPc_q;
        fetch_cnt   = fetchCnt_q;
    end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Testbench for ifu_pc_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based
// reference model of the fetch PC rules.
module tb_ifu_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam int          AW       = $clog2(IM_WORDS);

    logic          clk;
    logic          reset;
    logic          stall;
    logic          imem_ready;
    logic          br_req;
    logic [1:0]    br_type;
    logic          cmp_res;
    logic [31:0]   pc_d;
    logic [15:0]   imm16;
    logic [25:0]   instr_index;
    logic [31:0]   jr_addr;
    logic [31:0]   pc_f;
    logic [31:0]   pc_f_plus4;
    logic [AW-1:0] imem_addr;
    logic          fetch_valid;
    logic          fault;
    logic [31:0]   fault_pc;
    logic [31:0]   fetch_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        brReq;
        logic [1:0]  brType;
        logic        cmpRes;
        logic [31:0] pcD;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] expPc;
        logic [31:0] expCnt;
        logic        expFault;
        logic [31:0] expFaultPc;
    } vec_t;

    // Reference model state: the buffered redirect is a queue of at most one.
    logic [31:0] mPc;
    logic        mFault;
    logic [31:0] mFaultPc;
    logic [31:0] mCnt;
    logic [31:0] mPend[$];

    ifu_pc_ctrl #(
        .RESET_PC(RESET_PC),
        .IM_WORDS(IM_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .br_req      (br_req),
        .br_type     (br_type),
        .cmp_res     (cmp_res),
        .pc_d        (pc_d),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_addr     (jr_addr),
        .pc_f        (pc_f),
        .pc_f_plus4  (pc_f_plus4),
        .imem_addr   (imem_addr),
        .fetch_valid (fetch_valid),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .fetch_cnt   (fetch_cnt)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mkStim(input logic st, input logic rdy, input logic br,
                                     input logic [1:0] ty, input logic cmp,
                                     input logic [31:0] pcD, input logic [15:0] imm,
                                     input logic [25:0] idx, input logic [31:0] jr);
        stim_t s;
        s.stall  = st;
        s.ready  = rdy;
        s.brReq  = br;
        s.brType = ty;
        s.cmpRes = cmp;
        s.pcD    = pcD;
        s.imm    = imm;
        s.idx    = idx;
        s.jr     = jr;
        return s;
    endfunction

    function automatic stim_t idleStim(input logic st, input logic rdy);
        return mkStim(st, rdy, 1'b0, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic [31:0] pc, input logic [31:0] cnt,
                                   input logic flt, input logic [31:0] fpc);
        vec_t v;
        v.s          = s;
        v.expPc      = pc;
        v.expCnt     = cnt;
        v.expFault   = flt;
        v.expFaultPc = fpc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Check every output against a full expected state.
    task automatic checkAll(input string tag, input logic [31:0] ePc, input logic [31:0] eCnt,
                            input logic eFault, input logic [31:0] eFaultPc);
        logic [31:0] eAddr;
        eAddr = (ePc - RESET_PC) >> 2;
        checkOutput({tag, ".pc_f"}, pc_f, ePc);
        checkOutput({tag, ".pc_f_plus4"}, pc_f_plus4, ePc + 32'd4);
        checkOutput({tag, ".imem_addr"}, 32'(imem_addr), {20'd0, eAddr[AW-1:0]});
        checkOutput({tag, ".fault"}, 32'(fault), 32'(eFault));
        checkOutput({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(!eFault));
        checkOutput({tag, ".fault_pc"}, fault_pc, eFaultPc);
        checkOutput({tag, ".fetch_cnt"}, fetch_cnt, eCnt);
    endtask

    // Drive one cycle of inputs, let the rising edge happen, sample 1 ns later.
    task automatic applyStimulus(input stim_t s);
        stall       = s.stall;
        imem_ready  = s.ready;
        br_req      = s.brReq;
        br_type     = s.brType;
        cmp_res     = s.cmpRes;
        pc_d        = s.pcD;
        imm16       = s.imm;
        instr_index = s.idx;
        jr_addr     = s.jr;
        @(posedge clk);
        #1;
    endtask

    function automatic void modelReset();
        mPc      = RESET_PC;
        mFault   = 1'b0;
        mFaultPc = 32'd0;
        mCnt     = 32'd0;
        mPend.delete();
    endfunction

    // Architectural rules: a taken redirect is remembered (latest wins) until
    // fetch advances; an advance fetches the remembered target or pc+4, and an
    // illegal address freezes everything behind a sticky fault.
    function automatic void modelStep(input stim_t s);
        logic        adv;
        logic        tkn;
        logic [31:0] tgt;
        logic [31:0] nxt;
        longint      n;
        int          off;
        if (mFault) return;
        adv = !s.stall && s.ready;
        tkn = s.brReq && ((s.brType == 2'd1) || (s.brType == 2'd2) || s.cmpRes);
        if (tkn) begin
            off = int'($signed(s.imm));
            if (s.brType == 2'd1)      tgt = {s.pcD[31:28], s.idx, 2'b00};
            else if (s.brType == 2'd2) tgt = s.jr;
            else                       tgt = s.pcD + 32'd4 + 32'(off * 4);
            mPend.delete();
            mPend.push_back(tgt);
        end
        if (adv) begin
            nxt = (mPend.size() != 0) ? mPend[0] : mPc + 32'd4;
            n   = longint'(nxt);
            if ((nxt % 4 == 0) && (n >= longint'(RESET_PC)) &&
                (n < longint'(RESET_PC) + 4 * longint'(IM_WORDS))) begin
                mPc  = nxt;
                mCnt = mCnt + 32'd1;
                mPend.delete();
            end else begin
                mFault   = 1'b1;
                mFaultPc = nxt;
            end
        end
    endfunction

    // Asynchronous reset asserted mid-cycle, held past one edge, released
    // away from the edge.
    task automatic doReset();
        stim_t s;
        s = idleStim(1'b0, 1'b1);
        stall = s.stall; imem_ready = s.ready; br_req = 1'b0; br_type = 2'b00;
        cmp_res = 1'b0; pc_d = 32'd0; imm16 = 16'd0; instr_index = 26'd0; jr_addr = 32'd0;
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("reset", RESET_PC, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        stim_t s;
        reset = 1'b1;
        s = idleStim(1'b0, 1'b1);
        stall = 1'b0; imem_ready = 1'b1; br_req = 1'b0; br_type = 2'b00; cmp_res = 1'b0;
        pc_d = 32'd0; imm16 = 16'd0; instr_index = 26'd0; jr_addr = 32'd0;
        #1;
        reset = 1'b0;
        #7;
        checkAll("por", RESET_PC, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vector table, applied back to back from reset.
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3004, 1, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3008, 2, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h300C, 3, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3010, 4, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b00, 1, 32'h300C, 16'h0003, 0, 0), 32'h301C, 5, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b00, 0, 32'h3018, 16'h0003, 0, 0), 32'h3020, 6, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b00, 1, 32'h301C, 16'hFFFF, 0, 0), 32'h301C, 7, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b11, 1, 32'h3018, 16'h0002, 0, 0), 32'h3024, 8, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b01, 0, 32'h3020, 0, 26'h0000C10, 0), 32'h3040, 9, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b10, 0, 32'h303C, 0, 0, 32'h3100), 32'h3100, 10, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 0), 32'h3100, 10, 0, 0));
        vecs.push_back(mkVec(mkStim(1, 1, 1, 2'b00, 1, 32'h30FC, 16'h0010, 0, 0), 32'h3100, 10, 0, 0));
        vecs.push_back(mkVec(idleStim(1, 1), 32'h3100, 10, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3140, 11, 0, 0));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3144, 12, 0, 0));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b10, 0, 32'h3140, 0, 0, 32'h3102), 32'h3144, 12, 1, 32'h3102));
        vecs.push_back(mkVec(mkStim(0, 1, 1, 2'b01, 0, 32'h3140, 0, 26'h0000C10, 0), 32'h3144, 12, 1, 32'h3102));
        vecs.push_back(mkVec(mkStim(1, 1, 1, 2'b10, 0, 32'h3140, 0, 0, 32'h3000), 32'h3144, 12, 1, 32'h3102));
        vecs.push_back(mkVec(idleStim(0, 1), 32'h3144, 12, 1, 32'h3102));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expCnt,
                     vecs[i].expFault, vecs[i].expFaultPc);
        end

        // Redirect resolved under a 3-cycle stall lands on the first advance.
        doReset();
        applyStimulus(idleStim(0, 1));
        applyStimulus(mkStim(1, 1, 1, 2'b00, 1, 32'h3000, 16'h0003, 0, 0));
        checkAll("stallA", 32'h3004, 1, 0, 0);
        applyStimulus(idleStim(1, 1));
        applyStimulus(idleStim(1, 1));
        checkAll("stallC", 32'h3004, 1, 0, 0);
        applyStimulus(idleStim(0, 1));
        checkAll("stallRel", 32'h3010, 2, 0, 0);
        applyStimulus(idleStim(0, 1));
        checkAll("stallNext", 32'h3014, 3, 0, 0);

        // Two redirects while blocked: the later one wins; a not-taken one
        // in between leaves it alone.
        applyStimulus(mkStim(0, 0, 1, 2'b10, 0, 32'h3010, 0, 0, 32'h3200));
        applyStimulus(mkStim(1, 1, 1, 2'b10, 0, 32'h3010, 0, 0, 32'h3300));
        applyStimulus(mkStim(1, 1, 1, 2'b00, 0, 32'h3010, 16'h0040, 0, 0));
        checkAll("lastWinsHold", 32'h3014, 3, 0, 0);
        applyStimulus(idleStim(0, 1));
        checkAll("lastWins", 32'h3300, 4, 0, 0);

        // Sequential step past the last legal word faults instead of wrapping.
        applyStimulus(mkStim(0, 1, 1, 2'b10, 0, 32'h32FC, 0, 0, 32'h6FFC));
        checkAll("lastWord", 32'h6FFC, 5, 0, 0);
        applyStimulus(idleStim(0, 1));
        checkAll("wrapFault", 32'h6FFC, 5, 1, 32'h7000);

        // Reset while a redirect is buffered discards it.
        doReset();
        applyStimulus(mkStim(1, 1, 1, 2'b10, 0, 32'h2FFC, 0, 0, 32'h3400));
        doReset();
        applyStimulus(idleStim(0, 1));
        checkAll("pendDropped", 32'h3004, 1, 0, 0);

        // Randomized traffic against the reference model.
        doReset();
        begin
            int faultAge;
            faultAge = 0;
            for (int i = 0; i < 3000; i++) begin
                stim_t r;
                logic [31:0] jrA;
                int immS;
                if (($urandom_range(0, 199) == 0) || (faultAge > 4)) begin
                    doReset();
                    faultAge = 0;
                end
                jrA  = RESET_PC + ($urandom_range(0, IM_WORDS - 1) << 2);
                if ($urandom_range(0, 39) == 0) jrA = jrA + 32'd2;
                immS = $urandom_range(0, 128) - 64;
                r = mkStim(($urandom_range(0, 4) == 0), ($urandom_range(0, 6) != 0),
                           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), mPc - 32'd4, 16'(immS),
                           26'(32'hC00 + $urandom_range(0, IM_WORDS - 1)), jrA);
                modelStep(r);
                applyStimulus(r);
                checkAll($sformatf("rnd%0d", i), mPc, mCnt, mFault, mFaultPc);
                if (mFault) faultAge++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
